// File: rtl/am_beep_scheduler.sv
// am_beep_scheduler
//   Sequences audio bursts for the AM beeper transmitter. Each accepted
//   request plays one beep with a click-free linear envelope: ramp up, hold
//   for on_len ticks, ramp down, then stay silent for gap_len ticks. The
//   enveloped tone drives the modulator's signed signal input.
//
//   Optional feature macro: AM_BEEP_CARRIER_KEY_EN
//     When defined, adds carrier_en. It is high while a beep is active
//     (RAMP_UP..RAMP_DOWN) and is aligned with signal_out.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    beep request handshake
//   req_on_len         hold time at full level, in ticks
//   req_gap_len        silent time after ramp down, in ticks
//   abort              cut the current beep short without a click
//   tone_in            signed 16-bit tone
//   signal_out         signed enveloped tone (2-cycle latency)
//   env                current envelope gain, 0..256
//   busy               scheduler not idle
//   done               one-cycle pulse when a beep (incl. gap) completes
//   carrier_en         (optional) carrier keying, aligned with signal_out
module am_beep_scheduler #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned ENV_STEP = 1,
  parameter int unsigned DUR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DUR_W-1:0] req_on_len,
  input  logic [DUR_W-1:0] req_gap_len,
  input  logic             abort,
  input  logic [15:0]      tone_in,
  output logic [15:0]      signal_out,
  output logic [8:0]       env,
  output logic             busy,
  output logic             done
`ifdef AM_BEEP_CARRIER_KEY_EN
  ,
  output logic             carrier_en
`endif
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [8:0]  STEP  = 9'(ENV_STEP);
  localparam logic [8:0]  FULL  = 9'd256;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD,
    RAMP_DOWN,
    GAP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic [DUR_W-1:0]   on_len;
  logic [DUR_W-1:0]   gap_len;
  logic [DUR_W-1:0]   dur_cnt;

  // Free-running tick generator.
  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Envelope sequencer. dur_cnt is shared between HOLD and GAP since they
  // never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      env     <= '0;
      on_len  <= '0;
      gap_len <= '0;
      dur_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          env <= '0;
          if (req_valid) begin
            on_len  <= req_on_len;
            gap_len <= req_gap_len;
            state   <= RAMP_UP;
          end
        end
        RAMP_UP: begin
          // Abort keeps the current level; the ramp down starts from it.
          if (abort) begin
            state <= RAMP_DOWN;
          end else if (tick) begin
            env <= env + STEP;
            if (env >= FULL - STEP) begin
              if (on_len == '0) begin
                state <= RAMP_DOWN;
              end else begin
                state   <= HOLD;
                dur_cnt <= on_len;
              end
            end
          end
        end
        HOLD: begin
          if (abort) begin
            state <= RAMP_DOWN;
          end else if (tick) begin
            dur_cnt <= dur_cnt - DUR_W'(1);
            if (dur_cnt == DUR_W'(1)) begin
              state <= RAMP_DOWN;
            end
          end
        end
        RAMP_DOWN: begin
          if (tick) begin
            if (env <= STEP) begin
              env <= '0;
              if (gap_len == '0) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                state   <= GAP;
                dur_cnt <= gap_len;
              end
            end else begin
              env <= env - STEP;
            end
          end
        end
        GAP: begin
          if (tick) begin
            dur_cnt <= dur_cnt - DUR_W'(1);
            if (dur_cnt == DUR_W'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage gain datapath. env <= 256 so the 25-bit product cannot
  // overflow and the >>>8 result always fits in 16 bits.
  logic signed [25:0] tone_x;
  logic signed [25:0] env_x;
  logic signed [25:0] mult;
  logic signed [24:0] prod;

  assign tone_x = 26'($signed(tone_in));
  assign env_x  = 26'($signed({1'b0, env}));
  assign mult   = tone_x * env_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= '0;
      signal_out <= '0;
    end else begin
      prod       <= 25'(mult);
      signal_out <= 16'(prod >>> 8);
    end
  end

`ifdef AM_BEEP_CARRIER_KEY_EN
  logic key_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_d1     <= 1'b0;
      carrier_en <= 1'b0;
    end else begin
      key_d1     <= (state == RAMP_UP) || (state == HOLD) || (state == RAMP_DOWN);
      carrier_en <= key_d1;
    end
  end
`endif

endmodule

// File: tb/tb_am_beep_scheduler.sv
// tb_am_beep_scheduler
//   Self-checking bench for am_beep_scheduler with TICK_DIV=4, ENV_STEP=64.
//   Expected envelope changes and done pulses (value plus cycle spacing) are
//   queued when a request is issued and popped as the DUT produces them.
module tb_am_beep_scheduler;

  localparam int TDIV = 4;
  localparam int STEP = 64;
  localparam int DW   = 16;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b1;
  logic          req_valid   = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_on_len  = '0;
  logic [DW-1:0] req_gap_len = '0;
  logic          abort       = 1'b0;
  logic [15:0]   tone_in     = '0;
  logic [15:0]   signal_out;
  logic [8:0]    env;
  logic          busy;
  logic          done;
`ifdef AM_BEEP_CARRIER_KEY_EN
  logic          carrier_en;
`endif

  always #5 clk = ~clk;

  am_beep_scheduler #(
    .TICK_DIV(TDIV),
    .ENV_STEP(STEP),
    .DUR_W(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_on_len(req_on_len),
    .req_gap_len(req_gap_len),
    .abort(abort),
    .tone_in(tone_in),
    .signal_out(signal_out),
    .env(env),
    .busy(busy),
    .done(done)
`ifdef AM_BEEP_CARRIER_KEY_EN
    ,
    .carrier_en(carrier_en)
`endif
  );

  typedef struct {
    int kind;   // 0 = env change, 1 = done pulse
    int val;
    int dly;    // cycles since previous event, -1 = don't care
  } ev_t;

  ev_t evq[$];

  int checks    = 0;
  int failures  = 0;
  int since     = 0;
  int tone_age  = 0;
  int model_env = 0;

  function automatic logic [15:0] scale(input logic [15:0] t, input int e);
    logic signed [63:0] p;
    p = $signed(t);
    p = p * e;
    p = p >>> 8;
    return p[15:0];
  endfunction

  task automatic cyc();
    @(negedge clk);
    since++;
    tone_age++;
  endtask

  task automatic set_tone(input logic [15:0] v);
    tone_in  = v;
    tone_age = 0;
  endtask

  task automatic push_ev(input int kind, input int val, input int dly);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.dly  = dly;
    evq.push_back(e);
  endtask

  task automatic push_beep(input int on, input int gap, input int first_dly);
    int d;
    d = first_dly;
    for (int v = STEP; v <= 256; v += STEP) begin
      push_ev(0, v, d);
      d = TDIV;
    end
    d = (on + 1) * TDIV;
    for (int v = 256 - STEP; v >= 0; v -= STEP) begin
      push_ev(0, v, d);
      d = TDIV;
    end
    push_ev(1, 1, gap * TDIV);
  endtask

  // Runs the clock, handles the request handshake, pops/compares queued
  // events, and checks signal_out against the gain model once stable.
  task automatic watch(input string name, input int budget, input int tail, input int abort_env);
    int   n;
    int   tail_left;
    int   prev_env;
    bit   acc_pend;
    ev_t  e;
    n         = 0;
    tail_left = tail;
    prev_env  = int'(env);
    acc_pend  = (req_valid && req_ready);
    while (n < budget && (evq.size() > 0 || tail_left > 0)) begin
      cyc();
      n++;
      if (abort) abort = 1'b0;
      if (acc_pend) begin
        req_valid = 1'b0;
        acc_pend  = 1'b0;
      end
      if (int'(env) != prev_env) begin
        checks++;
        if (evq.size() == 0 || evq[0].kind != 0) begin
          failures++;
          $display("FAIL %s unexpected_env: got %0d required no change from %0d", name, env, prev_env);
        end else begin
          e = evq.pop_front();
          if (int'(env) != e.val) begin
            failures++;
            $display("FAIL %s env_value: got %0d required %0d", name, env, e.val);
          end
          if (e.dly >= 0) begin
            checks++;
            if (since != e.dly) begin
              failures++;
              $display("FAIL %s env_timing (env=%0d): got %0d cycles required %0d", name, e.val, since, e.dly);
            end
          end
          model_env = e.val;
          since     = 0;
          if (e.val == abort_env) abort = 1'b1;
        end
        prev_env = int'(env);
      end
      if (done !== 1'b0) begin
        checks++;
        if (evq.size() == 0 || evq[0].kind != 1) begin
          failures++;
          $display("FAIL %s unexpected_done: got %b required 0", name, done);
        end else begin
          e = evq.pop_front();
          if (since != e.dly) begin
            failures++;
            $display("FAIL %s done_timing: got %0d cycles required %0d", name, since, e.dly);
          end
          since = 0;
        end
      end
      if (since >= 2 && tone_age >= 2) begin
        checks++;
        if (signal_out !== scale(tone_in, model_env)) begin
          failures++;
          $display("FAIL %s signal_out (env=%0d tone=%h): got %h required %h",
                   name, model_env, tone_in, signal_out, scale(tone_in, model_env));
        end
      end
      if (model_env != 0) begin
        checks++;
        if (req_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s req_ready_busy: got %b required 0", name, req_ready);
        end
      end
`ifdef AM_BEEP_CARRIER_KEY_EN
      if (model_env != 0 && since >= 2) begin
        checks++;
        if (carrier_en !== 1'b1) begin
          failures++;
          $display("FAIL %s carrier_en: got %b required 1", name, carrier_en);
        end
      end
`endif
      if (req_valid && req_ready) acc_pend = 1'b1;
      if (evq.size() == 0 && tail_left > 0) tail_left--;
    end
    if (evq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: got %0d pending events required 0", name, evq.size());
      evq.delete();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    cyc();
    cyc();
    checks += 4;
    if (env !== 9'd0)        begin failures++; $display("FAIL reset env: got %0d required 0", env); end
    if (signal_out !== 16'h0) begin failures++; $display("FAIL reset signal_out: got %h required 0000", signal_out); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL reset busy: got %b required 0", busy); end
    if (done !== 1'b0)       begin failures++; $display("FAIL reset done: got %b required 0", done); end
    rst_n = 1'b1;
    cyc();
    checks += 2;
    if (req_ready !== 1'b1)  begin failures++; $display("FAIL reset req_ready: got %b required 1", req_ready); end
    if (env !== 9'd0)        begin failures++; $display("FAIL reset env_after: got %0d required 0", env); end
    model_env = 0;
  endtask

  task automatic test_single_beep();
    set_tone(16'h4000);
    req_on_len  = 16'd3;
    req_gap_len = 16'd2;
    req_valid   = 1'b1;
    push_beep(3, 2, -1);
    watch("single", 200, 12, -1);
  endtask

  task automatic test_back_to_back();
    set_tone(16'h1234);
    req_on_len  = 16'd1;
    req_gap_len = 16'd1;
    req_valid   = 1'b1;
    push_beep(1, 1, -1);
    push_beep(2, 0, TDIV);   // second accept on the very IDLE cycle of done
    cyc();
    req_on_len  = 16'd2;
    req_gap_len = 16'd0;
    watch("back_to_back", 300, 12, -1);
  endtask

  task automatic test_zero_len();
    set_tone(16'h2000);
    req_on_len  = 16'd0;
    req_gap_len = 16'd0;
    req_valid   = 1'b1;
    push_beep(0, 0, -1);
    watch("zero_len", 200, 12, -1);
  endtask

  task automatic test_abort();
    set_tone(16'h7fff);
    req_on_len  = 16'd5;
    req_gap_len = 16'd2;
    req_valid   = 1'b1;
    push_ev(0, 64, -1);
    push_ev(0, 128, TDIV);
    push_ev(0, 64, TDIV);
    push_ev(0, 0, TDIV);
    push_ev(1, 1, 2 * TDIV);
    watch("abort", 200, 12, 128);
  endtask

  task automatic test_sign_scale();
    set_tone(16'h8000);
    req_on_len  = 16'd0;
    req_gap_len = 16'd0;
    req_valid   = 1'b1;
    push_beep(0, 0, -1);
    watch("sign_scale", 200, 12, -1);
  endtask

  task automatic test_reset_mid_hold();
    set_tone(16'h4000);
    req_on_len  = 16'd3;
    req_gap_len = 16'd2;
    req_valid   = 1'b1;
    for (int v = STEP; v <= 256; v += STEP) push_ev(0, v, (v == STEP) ? -1 : TDIV);
    watch("rst_pre", 100, 0, -1);
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (env !== 9'd0)         begin failures++; $display("FAIL rst_mid env: got %0d required 0", env); end
    if (signal_out !== 16'h0) begin failures++; $display("FAIL rst_mid signal_out: got %h required 0000", signal_out); end
    if (busy !== 1'b0)        begin failures++; $display("FAIL rst_mid busy: got %b required 0", busy); end
    if (done !== 1'b0)        begin failures++; $display("FAIL rst_mid done: got %b required 0", done); end
    cyc();
    rst_n     = 1'b1;
    model_env = 0;
    since     = 0;
    watch("rst_post", 60, 40, -1);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_post req_ready: got %b required 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_single_beep();
    test_back_to_back();
    test_zero_len();
    test_abort();
    test_sign_scale();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/am_beep_scheduler.md
Name: am_beep_scheduler

Overview:
- Sequences audio bursts into the AM modulator datapath of the beeper transmitter.
- Accepts beep requests (on-time, gap-time) over a valid/ready handshake.
- Applies a click-free linear envelope (ramp up, hold, ramp down, gap) to a 16-bit signed tone.
- Drives the modulator's signed 16-bit signal input; the carrier path is untouched.

Parameters:
- TICK_DIV, 1000, clk cycles per envelope tick (>=2).
- ENV_STEP, 1, envelope increment per tick; power of two, 1..256. Ramp length = 256/ENV_STEP ticks.
- DUR_W, 16, width of on/gap duration fields, in ticks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  beep request present
- req_ready  out  1  scheduler can accept request
- req_on_len  in  DUR_W  hold time at full level, ticks
- req_gap_len  in  DUR_W  silent time after ramp down, ticks
- abort  in  1  cut current beep short, click-free
- tone_in  in  16  signed audio tone
- signal_out  out  16  signed enveloped tone, to modulator signal input
- env  out  9  current envelope gain, 0..256
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of GAP

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, env=0, signal_out=0, done=0, busy=0, tick counter=0, req_ready=1 after reset releases.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1; never stops.
  - tick=1 for one cycle when counter==TICK_DIV-1.
  - All envelope and duration changes occur only on tick cycles.
- Handshake:
  - req_ready = (state==IDLE).
  - Accept on req_valid & req_ready. On accept, latch on_len and gap_len and go to RAMP_UP on the next cycle.
  - Requests are never dropped: req_valid held while not ready waits.
- States:
  - IDLE: wait for request; env=0.
  - RAMP_UP: on tick, env += ENV_STEP. On the tick where env reaches 256, go to HOLD, or to RAMP_DOWN if on_len==0.
  - HOLD: env=256. Down-counter loaded with on_len, decremented each tick. On the tick it reaches 0, go to RAMP_DOWN. Hold lasts exactly on_len ticks.
  - RAMP_DOWN: on tick, env -= ENV_STEP. On the tick where env reaches 0, go to GAP, or to IDLE with done if gap_len==0.
  - GAP: env=0 for exactly gap_len ticks, then IDLE. done pulses the cycle state returns to IDLE.
- Abort:
  - abort in RAMP_UP or HOLD: next state RAMP_DOWN, ramping from the current env value. No env step is skipped.
  - abort ignored in IDLE, RAMP_DOWN, GAP.
  - abort and an accepted request in the same IDLE cycle: request taken, abort ignored.
- Datapath (2-cycle latency from tone_in and env to signal_out):
  - Stage 1 registers product = signed(tone_in) * signed({1'b0,env}), 25-bit signed.
  - Stage 2 registers signal_out = product >>> 8, truncated to [15:0].
  - No overflow is possible since env<=256. With env==256, signal_out equals tone_in delayed by 2 cycles; with env==0, signal_out==0.
- Reset mid-operation: immediate return to reset values. Latched request is discarded; no done pulse.

Optional Feature:
- Macro AM_BEEP_CARRIER_KEY_EN.
- Defined:
  - Adds output carrier_en (1 bit, reset 0).
  - carrier_en is high from the cycle state enters RAMP_UP until the cycle state leaves RAMP_DOWN, registered with the same 2-cycle delay as signal_out.
  - Upstream logic zeroes the modulator carrier when carrier_en is low, so nothing is radiated between beeps.
- Not defined: port absent, carrier runs continuously, all other behaviour identical.

Test Plan:
- Common setup: TICK_DIV=4, ENV_STEP=64.
- Single beep: tone_in=16'h4000 constant, request on_len=3, gap_len=2 → env steps 0,64,128,192,256 every 4 clks; hold 3 ticks; then 192..0; done exactly 2 ticks after env hits 0; signal_out=16'h4000 during HOLD (2-clk delay).
- Back-pressure: req_valid held during busy beep → req_ready=0 until IDLE; second request accepted the cycle state==IDLE; exactly 2 done pulses.
- Zero lengths: on_len=0, gap_len=0 → env 64,128,192,256,192,128,64,0, no HOLD/GAP cycles, done in the same cycle state returns to IDLE.
- Abort: abort pulsed when env=128 in RAMP_UP → env 64 then 0 on next ticks, then GAP for gap_len ticks, done asserted.
- Sign/scale: tone_in=16'h8000, env=128 in HOLD-equivalent test → signal_out=16'hC000; env=0 → 0.
- Reset mid-HOLD: rst_n low asynchronously → signal_out=0, env=0, busy=0 with no clk edge; no done pulse after release.
